// File: rtl/mvm_noc_pkg.sv
// Shared NoC constants, tuser field layout, sequencer FSM states and output beat format.
// Pure declarations; no latency or flow control of its own.
package mvm_noc_pkg;
    localparam int DATAW     = 512;
    localparam int USERW     = 75;
    localparam int DESTW     = 12;
    localparam int IDW       = 32;
    localparam int RF_LINES  = 64;
    localparam int MAX_NODES = 64;
    localparam int RF_ADDRW  = 9;
    localparam int CNTW      = $clog2(MAX_NODES + 1);
    localparam int LINEW     = $clog2(RF_LINES);

    localparam int ADDR_LSB  = 0;
    localparam int OP_LSB    = 9;
    localparam int LINE_LSB  = 11;

    localparam logic [1:0] OP_RF_WRITE = 2'b11;
    localparam logic [1:0] OP_VEC      = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_LOAD_V,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [DESTW-1:0] dest;
        logic [USERW-1:0] user;
        logic [IDW-1:0]   id;
        logic             last;
    } m_beat_t;

    localparam int M_BEATW = $bits(m_beat_t);

    function automatic logic [USERW-1:0] tuser_rf_write(input logic [RF_ADDRW-1:0] addr,
                                                        input logic [LINEW-1:0]    line);
        logic [USERW-1:0] u;
        u = '0;
        u[ADDR_LSB +: RF_ADDRW] = addr;
        u[OP_LSB +: 2]          = OP_RF_WRITE;
        u[LINE_LSB +: RF_LINES] = RF_LINES'(1) << line;
        return u;
    endfunction

    function automatic logic [USERW-1:0] tuser_vec();
        logic [USERW-1:0] u;
        u = '0;
        u[OP_LSB +: 2] = OP_VEC;
        return u;
    endfunction
endpackage

// File: rtl/mvm_load_sequencer_if.sv
// Weight, vector and NoC-injection AXIS streams of the MVM load sequencer.
// master = host/NoC side, slave = sequencer side.
interface mvm_load_sequencer_if;
    logic                             W_TVALID;
    logic                             W_TREADY;
    logic [mvm_noc_pkg::DATAW-1:0]    W_TDATA;
    logic                             V_TVALID;
    logic                             V_TREADY;
    logic [mvm_noc_pkg::DATAW-1:0]    V_TDATA;
    logic                             M_TVALID;
    logic                             M_TREADY;
    logic [mvm_noc_pkg::DATAW-1:0]    M_TDATA;
    logic [mvm_noc_pkg::DESTW-1:0]    M_TDEST;
    logic [mvm_noc_pkg::USERW-1:0]    M_TUSER;
    logic [mvm_noc_pkg::IDW-1:0]      M_TID;
    logic                             M_TLAST;

    modport master (
        output W_TVALID, W_TDATA, V_TVALID, V_TDATA, M_TREADY,
        input  W_TREADY, V_TREADY, M_TVALID, M_TDATA, M_TDEST, M_TUSER, M_TID, M_TLAST
    );

    modport slave (
        input  W_TVALID, W_TDATA, V_TVALID, V_TDATA, M_TREADY,
        output W_TREADY, V_TREADY, M_TVALID, M_TDATA, M_TDEST, M_TUSER, M_TID, M_TLAST
    );
endinterface

// File: rtl/axis_reg_slice.sv
// Single-entry forward register slice: one cycle source-to-output, full throughput.
// Accepts when empty or draining this cycle; output holds stable while stalled.
module axis_reg_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_vld_i,
    output logic         s_rdy_o,
    input  logic [W-1:0] s_dat_i,
    output logic         m_vld_o,
    input  logic         m_rdy_i,
    output logic [W-1:0] m_dat_o
);
    logic         vld_q;
    logic [W-1:0] dat_q;

    assign s_rdy_o = !vld_q || m_rdy_i;
    assign m_vld_o = vld_q;
    assign m_dat_o = dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else if (s_rdy_o) begin
            vld_q <= s_vld_i;
            if (s_vld_i) begin
                dat_q <= s_dat_i;
            end
        end
    end
endmodule

// File: rtl/mvm_load_sequencer.sv
// Turns a weight-line stream and a vector stream into RF-write packets per node, then one vector packet.
// Latency 1 cycle source-to-M_TVALID; W/V ready follow the output slice's ready.
module mvm_load_sequencer
    import mvm_noc_pkg::*;
(
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic [CNTW-1:0]     CFG_NUM_NODES,
    input  logic [DESTW-1:0]    CFG_FIRST_DEST,
    input  logic [DESTW-1:0]    CFG_VEC_DEST,
    input  logic [RF_ADDRW-1:0] CFG_RF_ADDR,
    mvm_load_sequencer_if.slave bus,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);
    state_e                state_q, state_d;
    logic [CNTW-1:0]       node_cnt_q, node_cnt_d;
    logic [LINEW-1:0]      line_cnt_q, line_cnt_d;
    logic [CNTW-1:0]       num_nodes_q, num_nodes_d;
    logic [DESTW-1:0]      first_dest_q, first_dest_d;
    logic [DESTW-1:0]      vec_dest_q, vec_dest_d;
    logic [RF_ADDRW-1:0]   rf_addr_q, rf_addr_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;

    logic                  slc_s_rdy;
    logic                  slc_m_vld;
    logic [M_BEATW-1:0]    slc_m_dat;
    m_beat_t               src_beat;
    m_beat_t               out_beat;
    logic                  w_fire, v_fire, m_fire;
    logic                  cfg_ok, last_line, last_node;

    assign bus.W_TREADY = (state_q == ST_LOAD_W) && slc_s_rdy;
    assign bus.V_TREADY = (state_q == ST_LOAD_V) && slc_s_rdy;
    assign w_fire       = bus.W_TVALID && bus.W_TREADY;
    assign v_fire       = bus.V_TVALID && bus.V_TREADY;
    assign m_fire       = slc_m_vld && bus.M_TREADY;

    assign cfg_ok    = (CFG_NUM_NODES != '0) && (CFG_NUM_NODES <= CNTW'(MAX_NODES));
    assign last_line = (line_cnt_q == LINEW'(RF_LINES - 1));
    assign last_node = (node_cnt_q == num_nodes_q - CNTW'(1));

    always_comb begin
        src_beat      = '0;
        src_beat.last = 1'b1;
        if (state_q == ST_LOAD_V) begin
            src_beat.data = bus.V_TDATA;
            src_beat.dest = vec_dest_q;
            src_beat.user = tuser_vec();
        end else begin
            src_beat.data = bus.W_TDATA;
            src_beat.dest = first_dest_q + DESTW'(node_cnt_q);
            src_beat.user = tuser_rf_write(rf_addr_q, line_cnt_q);
            src_beat.id   = IDW'(node_cnt_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        node_cnt_d   = node_cnt_q;
        line_cnt_d   = line_cnt_q;
        num_nodes_d  = num_nodes_q;
        first_dest_d = first_dest_q;
        vec_dest_d   = vec_dest_q;
        rf_addr_d    = rf_addr_q;
        err_d        = err_q;
        done_d       = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (cfg_ok) begin
                        num_nodes_d  = CFG_NUM_NODES;
                        first_dest_d = CFG_FIRST_DEST;
                        vec_dest_d   = CFG_VEC_DEST;
                        rf_addr_d    = CFG_RF_ADDR;
                        node_cnt_d   = '0;
                        line_cnt_d   = '0;
                        err_d        = 1'b0;
                        state_d      = ST_LOAD_W;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD_W: begin
                if (w_fire) begin
                    if (last_line) begin
                        line_cnt_d = '0;
                        if (last_node) begin
                            state_d = ST_LOAD_V;
                        end else begin
                            node_cnt_d = node_cnt_q + CNTW'(1);
                        end
                    end else begin
                        line_cnt_d = line_cnt_q + LINEW'(1);
                    end
                end
            end
            ST_LOAD_V: begin
                if (v_fire) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                // Only the vector beat can be in the slice here, so its drain ends the sequence.
                if (m_fire) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            node_cnt_q   <= '0;
            line_cnt_q   <= '0;
            num_nodes_q  <= '0;
            first_dest_q <= '0;
            vec_dest_q   <= '0;
            rf_addr_q    <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            node_cnt_q   <= node_cnt_d;
            line_cnt_q   <= line_cnt_d;
            num_nodes_q  <= num_nodes_d;
            first_dest_q <= first_dest_d;
            vec_dest_q   <= vec_dest_d;
            rf_addr_q    <= rf_addr_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    axis_reg_slice #(.W(M_BEATW)) u_out_slice (
        .clk     (CLK),
        .rst_n   (RST_N),
        .s_vld_i (w_fire || v_fire),
        .s_rdy_o (slc_s_rdy),
        .s_dat_i (src_beat),
        .m_vld_o (slc_m_vld),
        .m_rdy_i (bus.M_TREADY),
        .m_dat_o (slc_m_dat)
    );

    assign out_beat     = slc_m_dat;
    assign bus.M_TVALID = slc_m_vld;
    assign bus.M_TDATA  = out_beat.data;
    assign bus.M_TDEST  = out_beat.dest;
    assign bus.M_TUSER  = out_beat.user;
    assign bus.M_TID    = out_beat.id;
    assign bus.M_TLAST  = out_beat.last;

    assign BUSY = (state_q != ST_IDLE);
    assign DONE = done_q;
    assign ERR  = err_q;
endmodule

// File: tb/tb_mvm_load_sequencer.sv
// Directed bench for mvm_load_sequencer: table of load configurations plus reset and busy-START sequences.
module tb_mvm_load_sequencer;
    import mvm_noc_pkg::*;

    typedef struct {
        int                  nodes;
        logic [DESTW-1:0]    first;
        logic [DESTW-1:0]    vdest;
        logic [RF_ADDRW-1:0] addr;
        int                  rdy_pct;
        bit                  early_v;
        int                  poke;
        bit                  exp_err;
        int                  exp_beats;
    } vec_t;

    logic                CLK;
    logic                RST_N;
    logic                START;
    logic [CNTW-1:0]     CFG_NUM_NODES;
    logic [DESTW-1:0]    CFG_FIRST_DEST;
    logic [DESTW-1:0]    CFG_VEC_DEST;
    logic [RF_ADDRW-1:0] CFG_RF_ADDR;
    logic                BUSY, DONE, ERR;

    mvm_load_sequencer_if bus();

    mvm_load_sequencer dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .START          (START),
        .CFG_NUM_NODES  (CFG_NUM_NODES),
        .CFG_FIRST_DEST (CFG_FIRST_DEST),
        .CFG_VEC_DEST   (CFG_VEC_DEST),
        .CFG_RF_ADDR    (CFG_RF_ADDR),
        .bus            (bus),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERR            (ERR)
    );

    int n_chk = 0;
    int n_bad = 0;
    vec_t tv[8];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DATAW-1:0] wdat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 + 32'(k);
        return {16{w}};
    endfunction

    function automatic logic [DATAW-1:0] vdat(input int idx);
        logic [31:0] w;
        w = 32'h7EC70000 + 32'(idx);
        return {16{w}};
    endfunction

    task automatic chk_reset(input string pfx);
        chk({pfx, "_m_tvalid"}, bus.M_TVALID, 0);
        chk({pfx, "_m_tdata"},  bus.M_TDATA, 0);
        chk({pfx, "_m_tdest"},  bus.M_TDEST, 0);
        chk({pfx, "_m_tuser"},  bus.M_TUSER, 0);
        chk({pfx, "_m_tid"},    bus.M_TID, 0);
        chk({pfx, "_m_tlast"},  bus.M_TLAST, 0);
        chk({pfx, "_w_tready"}, bus.W_TREADY, 0);
        chk({pfx, "_v_tready"}, bus.V_TREADY, 0);
        chk({pfx, "_busy"},     BUSY, 0);
        chk({pfx, "_done"},     DONE, 0);
        chk({pfx, "_err"},      ERR, 0);
    endtask

    task automatic check_beat(input vec_t v, input int idx, input int k);
        int               nw, node, line;
        logic [DESTW-1:0] e_dest;
        logic [USERW-1:0] e_user;
        logic [IDW-1:0]   e_id;
        logic [DATAW-1:0] e_dat;
        nw = v.nodes * RF_LINES;
        e_user = '0;
        if (k < nw) begin
            node = k / RF_LINES;
            line = k % RF_LINES;
            e_dest = v.first + DESTW'(node);
            e_user[8:0]   = v.addr;
            e_user[10:9]  = 2'b11;
            e_user[11 + line] = 1'b1;
            e_id  = IDW'(node);
            e_dat = wdat(k);
        end else begin
            e_dest = v.vdest;
            e_user[10:9] = 2'b10;
            e_id  = '0;
            e_dat = vdat(idx);
        end
        chk($sformatf("r%0d_b%0d_tdata", idx, k), bus.M_TDATA, e_dat);
        chk($sformatf("r%0d_b%0d_tdest", idx, k), bus.M_TDEST, e_dest);
        chk($sformatf("r%0d_b%0d_tuser", idx, k), bus.M_TUSER, e_user);
        chk($sformatf("r%0d_b%0d_tid", idx, k),   bus.M_TID, e_id);
        chk($sformatf("r%0d_b%0d_tlast", idx, k), bus.M_TLAST, 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  nw, widx, mbeat, done_cnt, post, cyc, budget, early_bad, mseen;
        bit  v_sent, hold, w_acc, v_acc;
        logic [DATAW-1:0] h_dat;
        logic [119:0]     h_side;
        nw = v.nodes * RF_LINES;
        widx = 0; mbeat = 0; done_cnt = 0; post = 0; cyc = 0; early_bad = 0; mseen = 0;
        v_sent = 0; hold = 0; h_dat = '0; h_side = '0;
        budget = (nw + 1) * ((v.rdy_pct >= 100) ? 1 : 5) + 100;

        CFG_NUM_NODES  = CNTW'(v.nodes);
        CFG_FIRST_DEST = v.first;
        CFG_VEC_DEST   = v.vdest;
        CFG_RF_ADDR    = v.addr;
        START = 1'b1;
        step();
        START = 1'b0;
        chk($sformatf("r%0d_err_after_start", idx), ERR, v.exp_err);
        chk($sformatf("r%0d_busy_after_start", idx), BUSY, !v.exp_err);

        if (v.exp_err) begin
            for (int c = 0; c < 6; c++) begin
                bus.W_TVALID = 1'b1;
                bus.V_TVALID = 1'b1;
                bus.M_TREADY = 1'b1;
                @(negedge CLK);
                if (bus.M_TVALID || bus.W_TREADY || bus.V_TREADY || BUSY) mseen++;
                step();
            end
            chk($sformatf("r%0d_err_idle_activity", idx), mseen, 0);
            chk($sformatf("r%0d_err_sticky", idx), ERR, 1);
            bus.W_TVALID = 1'b0;
            bus.V_TVALID = 1'b0;
            bus.M_TREADY = 1'b0;
            return;
        end

        while (cyc < budget && post < 3) begin
            START          = (cyc == v.poke);
            CFG_FIRST_DEST = (cyc == v.poke) ? ~v.first : v.first;
            CFG_NUM_NODES  = (cyc == v.poke) ? CNTW'(1) : CNTW'(v.nodes);
            bus.W_TVALID   = (widx < nw);
            bus.W_TDATA    = wdat(widx);
            bus.V_TVALID   = !v_sent && (v.early_v || widx >= nw);
            bus.V_TDATA    = vdat(idx);
            bus.M_TREADY   = (v.rdy_pct >= 100) || ($urandom_range(0, 99) < v.rdy_pct);
            @(negedge CLK);
            if (bus.V_TREADY && widx < nw) early_bad++;
            if (hold) begin
                chk($sformatf("r%0d_stall_side", idx),
                    {bus.M_TVALID, bus.M_TDEST, bus.M_TUSER, bus.M_TID}, {1'b1, h_side[118:0]});
                chk($sformatf("r%0d_stall_data", idx), bus.M_TDATA, h_dat);
            end
            if (bus.M_TVALID && bus.M_TREADY) begin
                check_beat(v, idx, mbeat);
                mbeat++;
            end
            hold   = bus.M_TVALID && !bus.M_TREADY;
            h_dat  = bus.M_TDATA;
            h_side = {1'b1, bus.M_TDEST, bus.M_TUSER, bus.M_TID};
            w_acc  = bus.W_TVALID && bus.W_TREADY;
            v_acc  = bus.V_TVALID && bus.V_TREADY;
            if (DONE) begin
                done_cnt++;
                chk($sformatf("r%0d_busy_at_done", idx), BUSY, 0);
                chk($sformatf("r%0d_beats_at_done", idx), mbeat, nw + 1);
            end
            if (done_cnt > 0) post++;
            step();
            cyc++;
            if (w_acc) widx++;
            if (v_acc) v_sent = 1'b1;
        end
        START = 1'b0;
        bus.W_TVALID = 1'b0;
        bus.V_TVALID = 1'b0;
        bus.M_TREADY = 1'b0;
        chk($sformatf("r%0d_finished_in_budget", idx), post >= 3, 1);
        chk($sformatf("r%0d_beats", idx), mbeat, v.exp_beats);
        chk($sformatf("r%0d_w_accepted", idx), widx, nw);
        chk($sformatf("r%0d_v_accepted", idx), v_sent, 1);
        chk($sformatf("r%0d_done_pulses", idx), done_cnt, 1);
        chk($sformatf("r%0d_early_vready", idx), early_bad, 0);
        chk($sformatf("r%0d_err_end", idx), ERR, 0);
    endtask

    initial begin
        //        nodes first    vdest    addr     rdy  earlyV poke err beats
        tv[0] = '{3,  12'h001, 12'h0AB, 9'h001,  100, 1'b0, -1, 1'b0, 193};
        tv[1] = '{2,  12'h100, 12'h3C0, 9'h155,   50, 1'b0, 20, 1'b0, 129};
        tv[2] = '{2,  12'hFFF, 12'h123, 9'h1FF,  100, 1'b1, -1, 1'b0, 129};
        tv[3] = '{0,  12'h010, 12'h020, 9'h003,  100, 1'b0, -1, 1'b1, 0};
        tv[4] = '{1,  12'h040, 12'h041, 9'h000,  100, 1'b0, -1, 1'b0, 65};
        tv[5] = '{65, 12'h010, 12'h020, 9'h003,  100, 1'b0, -1, 1'b1, 0};
        tv[6] = '{64, 12'hFF0, 12'h800, 9'h0AA,  100, 1'b1, 70, 1'b0, 4097};
        tv[7] = '{1,  12'h7FF, 12'h001, 9'h111,   50, 1'b1, 5,  1'b0, 65};

        RST_N = 1'b0;
        START = 1'b0;
        CFG_NUM_NODES = '0;
        CFG_FIRST_DEST = '0;
        CFG_VEC_DEST = '0;
        CFG_RF_ADDR = '0;
        bus.W_TVALID = 1'b0;
        bus.W_TDATA = '0;
        bus.V_TVALID = 1'b0;
        bus.V_TDATA = '0;
        bus.M_TREADY = 1'b0;
        #3;
        chk_reset("por");
        @(negedge CLK);
        RST_N = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(tv[i], i);
        end

        // Reset partway through loading: ten weight beats in, then async reset.
        CFG_NUM_NODES  = CNTW'(1);
        CFG_FIRST_DEST = 12'h200;
        CFG_VEC_DEST   = 12'h201;
        CFG_RF_ADDR    = 9'h005;
        START = 1'b1;
        step();
        START = 1'b0;
        bus.W_TVALID = 1'b1;
        bus.M_TREADY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.W_TDATA = wdat(i);
            step();
        end
        chk("pre_reset_m_tvalid", bus.M_TVALID, 1);
        chk("pre_reset_m_tuser", bus.M_TUSER, {64'(1) << 9, 2'b11, 9'h005});
        RST_N = 1'b0;
        #1;
        chk_reset("mid");
        bus.W_TVALID = 1'b0;
        bus.M_TREADY = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        step();
        run_vec(tv[4], 4);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/mvm_load_sequencer.md
Name: mvm_load_sequencer

Overview:
Sequences MVM array loading over the NoC injection port. Takes a raw weight-line stream and an input-vector stream from the host side. Emits AXIS NoC packets: RF_LINES weight-write packets per MVM node, walking tdest across CFG_NUM_NODES nodes, then one input-vector packet. Sits between the host/DMA feed and the AXIS_S port of mvm_top.

Parameters:
DATAW, 512, NoC/RF data width
USERW, 75, tuser width ([8:0] RF addr, [10:9] op, [74:11] one-hot RF line)
DESTW, 12, tdest width
IDW, 32, tid width
RF_LINES, 64, weight lines per node; must equal USERW-11
MAX_NODES, 64, upper bound on CFG_NUM_NODES

Ports:
CLK  in  1  block clock
RST_N  in  1  asynchronous active-low reset
START  in  1  pulse: begin a load sequence (sampled only in IDLE)
CFG_NUM_NODES  in  $clog2(MAX_NODES+1)  nodes to load, 1..MAX_NODES; latched at START
CFG_FIRST_DEST  in  DESTW  tdest of first node; latched at START
CFG_VEC_DEST  in  DESTW  tdest for input vector; latched at START
CFG_RF_ADDR  in  9  RF address for weight writes; latched at START
W_TVALID / W_TREADY  in / out  1  weight-line stream handshake
W_TDATA  in  DATAW  one weight line per beat
V_TVALID / V_TREADY  in / out  1  input-vector stream handshake
V_TDATA  in  DATAW  vector word
M_TVALID / M_TREADY  out / in  1  NoC injection handshake
M_TDATA  out  DATAW  packet data
M_TDEST  out  DESTW  destination node
M_TUSER  out  USERW  op / addr / line select
M_TID  out  IDW  zero-extended node index (0 for the vector)
M_TLAST  out  1  always 1 while M_TVALID
BUSY  out  1  high from START accept through DONE
DONE  out  1  one-cycle pulse after the vector beat is accepted
ERR  out  1  sticky; set by START with CFG_NUM_NODES==0 or >MAX_NODES; cleared by the next valid START

Behaviour:
- Reset: state IDLE; M_TVALID, M_TDATA, M_TDEST, M_TUSER, M_TID, M_TLAST, W_TREADY, V_TREADY, BUSY, DONE, ERR all 0; counters 0.
- FSM states: IDLE, LOAD_W, LOAD_V, FINISH.
- IDLE:
  - Valid START: latch config, clear ERR, node_cnt=0, line_cnt=0, go to LOAD_W.
  - Invalid START: set ERR, stay in IDLE.
- Output stage: single register slice.
  - M_* register loads when empty or when M_TVALID&&M_TREADY in the same cycle.
  - Source ready = state match && (!M_TVALID || M_TREADY).
  - Full throughput: one beat per cycle with M_TREADY held high.
  - Latency: source beat to M_TVALID is 1 cycle.
  - M_* outputs hold stable while M_TVALID && !M_TREADY.
- LOAD_W, per accepted W beat:
  - M_TDATA=W_TDATA; M_TDEST=first_dest+node_cnt (mod 2^DESTW).
  - M_TUSER[8:0]=rf_addr; [10:9]=2'b11; [74:11]=one-hot bit line_cnt; M_TID=node_cnt.
  - line_cnt increments; at RF_LINES-1 it wraps to 0 and node_cnt increments.
  - After the beat with node_cnt==num_nodes-1 and line_cnt==RF_LINES-1: go to LOAD_V. V_TREADY stays 0 during LOAD_W.
- LOAD_V, one accepted V beat:
  - M_TDATA=V_TDATA; M_TDEST=vec_dest; M_TUSER[8:0]=0; [10:9]=2'b10; [74:11]=0; M_TID=0.
  - Go to FINISH.
- FINISH: wait until the output register drains (M_TVALID&&M_TREADY), pulse DONE, return to IDLE. BUSY drops in the same cycle DONE is asserted.
- W_TREADY is 0 outside LOAD_W; V_TREADY is 0 outside LOAD_V. Stream beats are never dropped or duplicated.
- START while BUSY is ignored; config is not re-latched.
- RST_N low mid-sequence: immediate return to reset values. Any in-flight M beat is discarded. Upstream is responsible for flushing.
- Unused M_TUSER bits above RF_LINES+10: 0.

Decomposition:
- Shared package mvm_noc_pkg: DATAW/USERW/DESTW/IDW, op codes (OP_RF_WRITE=2'b11, OP_VEC=2'b10), tuser field offsets (ADDR_LSB=0, OP_LSB=9, LINE_LSB=11), FSM state enum.
- Sub-module axis_reg_slice (DATAW+DESTW+USERW+IDW+1 payload, valid/ready, async active-low reset) for the output stage.

Test Plan:
1. NUM_NODES=3, FIRST_DEST=0x001, RF_ADDR=1, M_TREADY=1, 192 W beats + 1 V beat -> 193 M beats. Beat k: tdest=0x001+k/64, tuser[10:9]=3, tuser[11+k%64]=1. Last beat: tdest=VEC_DEST, op=2, line field 0. DONE pulses once.
2. Backpressure: M_TREADY random 50%, NUM_NODES=2 -> identical ordered output to the no-stall run. M_* stable during stalls. No W beat lost.
3. Early V_TVALID=1 throughout -> V_TREADY stays 0 until all 64*N weight beats are accepted. Vector is emitted last.
4. START with NUM_NODES=0 -> ERR=1, BUSY=0, no M beats. Next START with NUM_NODES=1 -> ERR clears, 65 beats.
5. RST_N asserted after 10 weight beats -> all outputs 0 immediately. New START restarts at line 0, node 0.
6. START pulsed while BUSY with different CFG_FIRST_DEST -> ignored; tdest sequence unchanged.
